// File: rtl/skip_sched_if.sv
// ============================================================================
//  Module      : skip_sched_if
//  Description : Bundle of control, table-write, request and ring-drive
//                signals between a controller (master) and the skip_sched
//                pattern scheduler (slave).
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Signals
//    RUN      master->slave  level, 1 = scheduling enabled
//    WE       master->slave  table write strobe
//    WADDR    master->slave  slot written
//    WMASK    master->slave  mask written
//    WDWELL   master->slave  dwell written (d => d+1 revolutions)
//    REQ      master->slave  slot-jump request, held until ACK
//    REQ_IDX  master->slave  requested slot
//    ACK      slave->master  one-cycle pulse when the request is applied
//    oMASK    slave->master  ring MASK
//    oSEL     slave->master  ring rSEL (constant select pattern)
//    oE       slave->master  ring E
//    oRRST    slave->master  ring RST (active-high)
//    CUR_IDX  slave->master  active slot
//    WRAP     slave->master  one-cycle pulse per completed revolution
// ============================================================================
`default_nettype none

interface skip_sched_if #(
    parameter int LEN = 16,
    parameter int AW  = 2,
    parameter int DW  = 8
);
    logic            RUN;
    logic            WE;
    logic [AW-1:0]   WADDR;
    logic [LEN-1:0]  WMASK;
    logic [DW-1:0]   WDWELL;
    logic            REQ;
    logic [AW-1:0]   REQ_IDX;
    logic            ACK;
    logic [LEN-1:0]  oMASK;
    logic [LEN-1:0]  oSEL;
    logic            oE;
    logic            oRRST;
    logic [AW-1:0]   CUR_IDX;
    logic            WRAP;

    modport master (
        output RUN, WE, WADDR, WMASK, WDWELL, REQ, REQ_IDX,
        input  ACK, oMASK, oSEL, oE, oRRST, CUR_IDX, WRAP
    );

    modport slave (
        input  RUN, WE, WADDR, WMASK, WDWELL, REQ, REQ_IDX,
        output ACK, oMASK, oSEL, oE, oRRST, CUR_IDX, WRAP
    );
endinterface

`default_nettype wire

// File: rtl/skip_sched.sv
// ============================================================================
//  Module      : skip_sched
//  Description : Pattern scheduler for one skipring. Holds NPAT = 2**AW skip
//                masks with per-slot dwell counts, steps through them on ring
//                revolution boundaries and accepts a req/ack slot-jump
//                override. Drives the ring's E, RST, rSEL and MASK inputs.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    iCLK   in   ring clock (divided LED clock)
//    nRST   in   synchronous active-low reset
//    bus    slave modport of skip_sched_if (control, table writes,
//                request handshake, ring drive and status outputs)
//
//  Configuration macro
//    SKIP_SCHED_SKIPEMPTY_EN  when defined, automatic advance skips slots
//                             whose mask is zero; otherwise plain +1 mod NPAT.
// ============================================================================
`default_nettype none

module skip_sched #(
    parameter int             LEN    = 16,
    parameter int             AW     = 2,
    parameter int             DW     = 8,
    parameter logic [LEN-1:0] defSEL = LEN'(1)
) (
    input  wire          iCLK,
    input  wire          nRST,
    skip_sched_if.slave  bus
);

    localparam int NPAT = 1 << AW;
    localparam int PW   = (LEN > 1) ? $clog2(LEN) : 1;
    localparam logic [PW-1:0] c_POS_LAST = PW'(LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_RUN   = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t          r_state;
    logic [LEN-1:0]  r_tab_mask  [NPAT];
    logic [DW-1:0]   r_tab_dwell [NPAT];
    logic [PW-1:0]   r_pos;
    logic [DW-1:0]   r_dcnt;
    logic [AW-1:0]   r_cur_idx;
    logic [LEN-1:0]  r_mask;
    logic            r_e;
    logic            r_rrst;
    logic            r_ack;
    logic            r_wrap;
    logic            r_pend_v;
    logic [AW-1:0]   r_pend_idx;

    // ------------------------------------------------------------------
    // Combinational next values
    // ------------------------------------------------------------------
    state_t          w_state_nxt;
    logic [LEN-1:0]  w_eff_mask  [NPAT];
    logic [DW-1:0]   w_eff_dwell [NPAT];
    logic [PW-1:0]   w_pos_nxt;
    logic [DW-1:0]   w_dcnt_nxt;
    logic [AW-1:0]   w_idx_nxt;
    logic [LEN-1:0]  w_mask_nxt;
    logic            w_e_nxt;
    logic            w_rrst_nxt;
    logic            w_ack_nxt;
    logic            w_wrap_nxt;
    logic            w_pend_v_nxt;
    logic [AW-1:0]   w_pend_idx_nxt;
    logic [AW-1:0]   w_adv_idx;
    logic            w_req_new;
    logic            w_req_sel_v;
    logic [AW-1:0]   w_req_sel_idx;
    logic            w_boundary;

    // Table contents as they will be after this edge. Every table read
    // goes through this view so that a write coinciding with a LOAD or a
    // boundary read of the same slot is seen immediately.
    always_comb begin
        for (int i = 0; i < NPAT; i++) begin
            w_eff_mask[i]  = r_tab_mask[i];
            w_eff_dwell[i] = r_tab_dwell[i];
        end
        if (bus.WE) begin
            w_eff_mask[bus.WADDR]  = bus.WMASK;
            w_eff_dwell[bus.WADDR] = bus.WDWELL;
        end
    end

    // Slot chosen by automatic advance.
`ifdef SKIP_SCHED_SKIPEMPTY_EN
    logic [AW-1:0] w_cand;

    // Scan the other slots from farthest to nearest so the nearest
    // nonzero one wins; if none qualify the active slot is kept.
    always_comb begin
        w_adv_idx = r_cur_idx;
        w_cand    = r_cur_idx;
        for (int k = NPAT - 1; k >= 1; k--) begin
            w_cand = r_cur_idx + AW'(k);
            if (w_eff_mask[w_cand] != '0) begin
                w_adv_idx = w_cand;
            end
        end
    end
`else
    always_comb begin
        w_adv_idx = r_cur_idx + AW'(1);
    end
`endif

    // A new request is only taken when nothing is pending and we are not in
    // the ACK cycle (REQ is still high there because the master has not
    // seen ACK yet).
    assign w_req_new     = bus.REQ && !r_pend_v && !r_ack;
    assign w_req_sel_v   = r_pend_v || w_req_new;
    assign w_req_sel_idx = r_pend_v ? r_pend_idx : bus.REQ_IDX;
    assign w_boundary    = (r_pos == c_POS_LAST);

    // ------------------------------------------------------------------
    // FSM next-state / output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt    = r_state;
        w_pos_nxt      = r_pos;
        w_dcnt_nxt     = r_dcnt;
        w_idx_nxt      = r_cur_idx;
        w_mask_nxt     = r_mask;
        w_e_nxt        = 1'b0;
        w_rrst_nxt     = 1'b0;
        w_ack_nxt      = 1'b0;
        w_wrap_nxt     = 1'b0;
        w_pend_v_nxt   = r_pend_v;
        w_pend_idx_nxt = r_pend_idx;

        // Latch a fresh request; a jump taken below overrides this.
        if (w_req_new) begin
            w_pend_v_nxt   = 1'b1;
            w_pend_idx_nxt = bus.REQ_IDX;
        end

        case (r_state)
            S_IDLE: begin
                if (bus.RUN) begin
                    // Outputs registered on this edge are the LOAD-cycle
                    // values; a request arriving now is applied at once.
                    w_state_nxt = S_LOAD;
                    w_rrst_nxt  = 1'b1;
                    w_pos_nxt   = '0;
                    w_dcnt_nxt  = '0;
                    if (w_req_sel_v) begin
                        w_idx_nxt    = w_req_sel_idx;
                        w_ack_nxt    = 1'b1;
                        w_pend_v_nxt = 1'b0;
                    end
                    w_mask_nxt = w_eff_mask[w_idx_nxt];
                end
            end

            S_LOAD: begin
                // Ring is reset during LOAD; first RUN cycle is position 0.
                w_state_nxt = S_RUN;
                w_e_nxt     = 1'b1;
            end

            S_RUN, S_DRAIN: begin
                w_e_nxt = 1'b1;
                if ((r_state == S_RUN) && !bus.RUN) begin
                    w_state_nxt = S_DRAIN;
                end
                if (w_boundary) begin
                    w_pos_nxt  = '0;
                    w_wrap_nxt = 1'b1;
                    // A request latched on this same edge is not yet in
                    // r_pend_v, so it waits for the following boundary.
                    if (r_pend_v) begin
                        w_idx_nxt    = r_pend_idx;
                        w_dcnt_nxt   = '0;
                        w_ack_nxt    = 1'b1;
                        w_pend_v_nxt = 1'b0;
                    end else if (r_dcnt == w_eff_dwell[r_cur_idx]) begin
                        w_idx_nxt  = w_adv_idx;
                        w_dcnt_nxt = '0;
                    end else begin
                        w_dcnt_nxt = r_dcnt + DW'(1);
                    end
                    w_mask_nxt = w_eff_mask[w_idx_nxt];
                    // Draining (or RUN dropped right on the boundary) ends
                    // here; the ring stops in the next cycle.
                    if ((r_state == S_DRAIN) || !bus.RUN) begin
                        w_state_nxt = S_IDLE;
                        w_e_nxt     = 1'b0;
                    end
                end else begin
                    w_pos_nxt = r_pos + PW'(1);
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge iCLK) begin
        if (!nRST) begin
            r_state    <= S_IDLE;
            r_pos      <= '0;
            r_dcnt     <= '0;
            r_cur_idx  <= '0;
            r_mask     <= '0;
            r_e        <= 1'b0;
            r_rrst     <= 1'b1;
            r_ack      <= 1'b0;
            r_wrap     <= 1'b0;
            r_pend_v   <= 1'b0;
            r_pend_idx <= '0;
            for (int i = 0; i < NPAT; i++) begin
                r_tab_mask[i]  <= '0;
                r_tab_dwell[i] <= '0;
            end
        end else begin
            r_state    <= w_state_nxt;
            r_pos      <= w_pos_nxt;
            r_dcnt     <= w_dcnt_nxt;
            r_cur_idx  <= w_idx_nxt;
            r_mask     <= w_mask_nxt;
            r_e        <= w_e_nxt;
            r_rrst     <= w_rrst_nxt;
            r_ack      <= w_ack_nxt;
            r_wrap     <= w_wrap_nxt;
            r_pend_v   <= w_pend_v_nxt;
            r_pend_idx <= w_pend_idx_nxt;
            for (int i = 0; i < NPAT; i++) begin
                r_tab_mask[i]  <= w_eff_mask[i];
                r_tab_dwell[i] <= w_eff_dwell[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Output drive
    // ------------------------------------------------------------------
    assign bus.oMASK   = r_mask;
    assign bus.oSEL    = defSEL;
    assign bus.oE      = r_e;
    assign bus.oRRST   = r_rrst;
    assign bus.ACK     = r_ack;
    assign bus.WRAP    = r_wrap;
    assign bus.CUR_IDX = r_cur_idx;

endmodule

`default_nettype wire

// File: doc/skip_sched.md
Name: skip_sched

Overview:
- Pattern scheduler for one skipring instance.
- Holds a small table of skip masks with per-slot dwell counts and drives the ring's E, RST, rSEL and MASK inputs.
- Mask changes happen only on ring revolution boundaries. The block steps through the slots automatically and also accepts a req/ack override that jumps to a chosen slot.
- Runs in the same clock domain as the ring (the divided LED clock).

Parameters:
- LEN, 16, ring length in bits (width of mask and select).
- AW, 2, slot address width; NPAT = 2**AW slots.
- DW, 8, dwell counter width; dwell value d means d+1 revolutions per slot.
- defSEL, LEN'b1, select pattern driven on oSEL and loaded into the ring on every oRRST.

Ports:
- iCLK  in  1  clock; the ring's iCLK.
- nRST  in  1  synchronous active-low reset.
- RUN  in  1  level; 1 = scheduling enabled.
- WE  in  1  table write strobe.
- WADDR  in  AW  slot written.
- WMASK  in  LEN  mask written.
- WDWELL  in  DW  dwell written.
- REQ  in  1  slot-jump request; held until ACK.
- REQ_IDX  in  AW  requested slot.
- ACK  out  1  one-cycle pulse when the request is applied.
- oMASK  out  LEN  to ring MASK.
- oSEL  out  LEN  to ring rSEL; constant defSEL.
- oE  out  1  to ring E.
- oRRST  out  1  to ring RST (active-high).
- CUR_IDX  out  AW  active slot.
- WRAP  out  1  one-cycle pulse per completed revolution.

Behaviour:
- All outputs are registered. Reset applies on the first iCLK edge with nRST=0, including mid-run.
- Reset values:
  - table masks = 0, dwells = 0;
  - oMASK = 0, oE = 0, oRRST = 1, ACK = 0, WRAP = 0, CUR_IDX = 0;
  - pos = 0, dcnt = 0, pending request cleared;
  - state = IDLE.
- Internal state: pos (0..LEN-1) mirrors the ring position. dcnt counts revolutions within the current slot. A pending-request register holds a latched REQ_IDX.
- FSM states: IDLE, LOAD, RUN, DRAIN.
- IDLE:
  - oE=0, oRRST=0.
  - RUN=1 goes to LOAD.
- LOAD (exactly 1 cycle):
  - oRRST=1, oE=0, pos=0, dcnt=0.
  - If a request is pending: CUR_IDX=pending index, ACK=1, pending cleared.
  - oMASK = table[CUR_IDX as updated].
  - Next state: RUN.
- RUN:
  - oE=1, pos increments every cycle.
  - Boundary = the cycle with pos==LEN-1. On that edge: pos goes to 0, WRAP=1 for one cycle, and the next slot is selected in this priority order:
    1. Pending request: CUR_IDX = pending index, dcnt=0, ACK=1.
    2. dcnt == dwell[CUR_IDX]: CUR_IDX = CUR_IDX+1 mod NPAT (wraps from NPAT-1 to 0), dcnt=0.
    3. Otherwise: dcnt+1, slot unchanged.
  - oMASK reloads from the selected slot on the same edge.
  - RUN=0 goes to DRAIN.
- DRAIN:
  - Continues as RUN until the next boundary, then goes to IDLE with oE=0 in the next cycle.
  - RUN re-asserted during DRAIN does not cancel it; the block passes through IDLE and then LOAD.
- Request handshake:
  - REQ=1 with nothing pending latches REQ_IDX.
  - REQ_IDX changes after latching are ignored until ACK.
  - A REQ seen in the ACK cycle is not re-latched.
  - A request arriving in the same cycle as a boundary is deferred to the next boundary, unless the state is LOAD.
- Table writes:
  - Accepted in any state.
  - A write to the active slot does not change oMASK until the next boundary or LOAD.
  - A write and a read of the same slot in the same cycle (LOAD or boundary) uses the new WMASK/WDWELL (bypass).
- Dwell comparison always uses the current table value of the active slot.

Optional Feature:
- SKIP_SCHED_SKIPEMPTY_EN defined:
  - Automatic advance (priority 2) selects the next slot after CUR_IDX, in circular order, whose mask is nonzero.
  - If every other slot is zero, CUR_IDX is kept and dcnt resets to 0.
  - Request-driven jumps ignore this rule; a zero slot may be requested.
- Undefined: plain +1 mod NPAT advance.

Test Plan:
- Reset hold, then release with RUN=0 -> oE=0, oRRST=0 after the first post-reset cycle, oMASK=0, CUR_IDX=0. Assert nRST=0 mid-RUN -> same values next edge.
- Write slots 0..3 with masks 16'h0001/16'h0003/16'h0045/16'h3445, dwell 0/1/0/2; set RUN=1 -> oRRST for 1 cycle, then WRAP every 16 cycles. CUR_IDX sequence is 0,1,1,2,3,3,3,0; oMASK changes only on WRAP edges.
- During slot 0, REQ=1 with REQ_IDX=3 -> ACK at the next boundary, CUR_IDX=3, dcnt restarts (3 revolutions in slot 3). REQ_IDX changed to 1 before ACK -> ignored.
- RUN=0 at pos=5 -> 10 more oE cycles, WRAP, then oE=0. RUN=1 again -> LOAD with oRRST=1, and the pending request is applied with ACK in LOAD.
- Write slot 1 while it is active with a new mask -> oMASK unchanged until the boundary. Write coinciding with the boundary load of slot 2 -> new mask appears.
- With SKIP_SCHED_SKIPEMPTY_EN and slots 1 and 2 zero -> sequence goes 0 to 3. With all slots except 0 zero -> stays on 0 and WRAP continues. Without the macro -> zero slots are visited.
